yarvi_retire_trace: RTL
=======================

Name: yarvi_retire_trace

Overview:
- Consumer end of the yarvi_ex retire port (retire_valid/priv/pc/insn/rd/wb_val).
- Captures each retired instruction into a small FIFO and serializes it as a fixed 13-byte record on a byte stream with a valid/ready handshake. The stream feeds a UART or host debug link.
- The retire port has no backpressure. When the FIFO is full, records are dropped and counted, and the loss is flagged in the next emitted record.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted); release is synchronised by the surrounding system
retire_valid  input  1  one instruction retires this cycle
retire_priv  input  2  privilege level of the retired instruction
retire_pc  input  32  PC of the retired instruction
retire_insn  input  32  instruction word
retire_rd  input  5  destination register; 0 = no writeback
retire_wb_val  input  32  writeback value
tx_valid  output  1  tx_data holds a valid byte
tx_data  output  8  trace byte
tx_ready  input  1  sink accepts the byte when tx_valid & tx_ready
drop_count  output  16  saturating count of dropped records
fifo_level  output  $clog2(DEPTH)+1  records currently buffered, including the one being sent

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO empty; fifo_level=0; tx_valid=0; tx_data=0; drop_count=0; pending_drop=0; byte index=0; state IDLE.
  - A record that was partially sent is discarded without notice.
- Capture:
  - On a clock where retire_valid=1 and fifo_level<DEPTH (registered value), write {pending_drop, priv, rd, pc, insn, wb_val} to the tail entry, then clear pending_drop.
  - If fifo_level==DEPTH, the record is dropped: drop_count+=1, saturating at 0xFFFF, and pending_drop is set.
  - A pop completing in the same cycle does not free a slot for that cycle's push. Full means registered full.
  - Push and pop in the same cycle leave fifo_level unchanged.
- Record format, sent in this byte order:
  - b0 = {drop_flag, priv[1:0], rd[4:0]}; drop_flag=1 means one or more records were lost immediately before this record.
  - b1..b4 = pc, little-endian.
  - b5..b8 = insn, little-endian.
  - b9..b12 = wb_val, little-endian.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty (registered), go to SEND with idx=0 and drive tx_valid=1, tx_data=b0 of the head entry on the next cycle.
  - SEND: tx_valid=1 and tx_data=b[idx]. Both stay stable until tx_ready=1.
  - On a handshake with idx<12: idx+=1, and the next byte appears on the following cycle with no bubble.
  - On a handshake with idx==12: pop the head, idx=0.
    - If another entry remains after the pop, stay in SEND and present its b0 on the next cycle.
    - Otherwise go to IDLE with tx_valid=0.
  - tx_valid never deasserts without a handshake, except on reset.
- Latency:
  - retire_valid into an empty FIFO at edge N gives tx_valid=1 with b0 after edge N+1.
  - With tx_ready held at 1, one record takes 13 cycles; sustained throughput is 1 record per 13 cycles.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_level is computed from a separate counter, not from pointer difference.
- Outputs are registered. There is no combinational path from retire_* or tx_ready to tx_valid or tx_data.

Test Plan:
1. Reset then one retire with pc=0x80000000, insn=0x00500093, rd=1, wb_val=5, priv=3, tx_ready=1:
   - Required bytes: 0x61,00,00,00,80,93,00,50,00,05,00,00,00.
   - tx_valid drops after byte 13; fifo_level returns to 0.
2. Same record with tx_ready toggling 1/0 every cycle:
   - Identical byte sequence.
   - tx_data stable while tx_valid & !tx_ready.
3. DEPTH=4, tx_ready=0, 6 back-to-back retires:
   - fifo_level=4; drop_count=2.
   - Raise tx_ready: 4 records emitted in order, all with b0[7]=0.
   - Next accepted retire emits b0[7]=1.
4. Continuous retires every 13 cycles with tx_ready=1, 20 records:
   - No drops; pointers wrap.
   - Every record matches its input; no bubbles between records.
5. Assert reset=0 asynchronously mid-record (idx=5):
   - tx_valid=0 and fifo_level=0 immediately, without waiting for a clock edge.
   - After release, the next retire emits a fresh b0.
6. tx_ready=0, 0x10005 drops forced:
   - drop_count saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/yarvi_retire_trace.sv
// Retire-port trace capture: buffers retired instructions in a small FIFO and
// serializes each as a 13-byte record on a valid/ready byte stream.
module yarvi_retire_trace #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     retire_valid,
  input  logic [1:0]               retire_priv,
  input  logic [31:0]              retire_pc,
  input  logic [31:0]              retire_insn,
  input  logic [4:0]               retire_rd,
  input  logic [31:0]              retire_wb_val,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 104;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [AW:0]     count_q, count_d;
  logic [3:0]      idx_q, idx_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [15:0]     drop_q, drop_d;
  logic            pend_q, pend_d;
  logic            full, push, pop;
  logic [EW-1:0]   wr_entry, next_head;

  // Entry layout: {drop_flag, priv, rd, pc, insn, wb_val}; bytes 1..12 little-endian.
  function automatic logic [7:0] sel_byte(input logic [EW-1:0] e, input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = e[103:96];
      4'd1:    b = e[71:64];
      4'd2:    b = e[79:72];
      4'd3:    b = e[87:80];
      4'd4:    b = e[95:88];
      4'd5:    b = e[39:32];
      4'd6:    b = e[47:40];
      4'd7:    b = e[55:48];
      4'd8:    b = e[63:56];
      4'd9:    b = e[7:0];
      4'd10:   b = e[15:8];
      4'd11:   b = e[23:16];
      4'd12:   b = e[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign push       = retire_valid & ~full;
  assign pop        = tx_valid_q & tx_ready & (idx_q == 4'd12);
  assign wr_entry   = {pend_q, retire_priv, retire_rd, retire_pc, retire_insn, retire_wb_val};
  assign rd_ptr_inc = rd_ptr_q + AW'(1);
  // With a single buffered record the follower is the one being written this cycle.
  assign next_head  = (count_q > (AW+1)'(1)) ? mem_q[rd_ptr_inc] : wr_entry;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    drop_d     = drop_q;
    pend_d     = pend_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      pend_d   = 1'b0;
    end else if (retire_valid) begin
      pend_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    if (pop) rd_ptr_d = rd_ptr_inc;

    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);

    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d    = StSend;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = sel_byte(mem_q[rd_ptr_q], 4'd0);
        end
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q != 4'd12) begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = sel_byte(mem_q[rd_ptr_q], idx_q + 4'd1);
          end else begin
            idx_d = 4'd0;
            if (count_q > (AW+1)'(1) || push) begin
              tx_data_d = sel_byte(next_head, 4'd0);
            end else begin
              state_d    = StIdle;
              tx_valid_d = 1'b0;
              tx_data_d  = 8'h00;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= 4'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      drop_q     <= 16'h0000;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
      pend_q     <= pend_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign drop_count = drop_q;
  assign fifo_level = count_q;

endmodule
